// File: rtl/uart_pkg.sv
// Shared definitions for the UART test-pattern source and the receive-side checker.
package uart_pkg;

  localparam logic [7:0] SYM0_DEF  = 8'hAA;
  localparam logic [7:0] SYM1_DEF  = 8'h55;
  localparam logic [7:0] SYM2_DEF  = 8'hCC;
  localparam logic [7:0] SYM3_DEF  = 8'h89;
  localparam int         CNT_W_DEF = 16;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } chk_state_t;

endpackage

// File: rtl/uart_data_checker_if.sv
// Receiver-to-checker byte interface: data, valid level and per-byte line errors.
interface uart_data_checker_if;

  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_FERROR;
  logic       Rx_PERROR;

  modport master (
    output Rx_DATA,
    output Rx_VALID,
    output Rx_FERROR,
    output Rx_PERROR
  );

  modport slave (
    input Rx_DATA,
    input Rx_VALID,
    input Rx_FERROR,
    input Rx_PERROR
  );

endinterface

// File: rtl/uart_data_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_q
);

  logic [CNT_W-1:0] r_q;
  logic             w_at_max;

  assign w_at_max = (r_q == {CNT_W{1'b1}});
  assign o_q      = r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_inc && !w_at_max) begin
      r_q <= r_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_data_checker.sv
// Checks received bytes against the repeating AA/55/CC/89 pattern and keeps
// saturating sequence-pass and error statistics.
module uart_data_checker
  import uart_pkg::*;
#(
  parameter logic [7:0] SYM0  = SYM0_DEF,
  parameter logic [7:0] SYM1  = SYM1_DEF,
  parameter logic [7:0] SYM2  = SYM2_DEF,
  parameter logic [7:0] SYM3  = SYM3_DEF,
  parameter int         CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  uart_data_checker_if.slave  rx,
  output logic                locked,
  output logic [1:0]          exp_idx,
  output logic                sym_ok,
  output logic                sym_err,
  output logic                seq_done,
  output logic [7:0]          last_rx,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  chk_state_t r_state;
  logic [1:0] r_exp_idx;
  logic       r_rx_valid_q;
  logic       r_sym_ok;
  logic       r_sym_err;
  logic       r_seq_done;
  logic [7:0] r_last_rx;

  logic       w_accept;
  logic       w_line_err;
  logic       w_match;
  logic       w_is_sym0;
  logic       w_pass_inc;
  logic       w_err_inc;
  logic [7:0] w_exp_sym;

  // r_rx_valid_q resets to 1 so a Rx_VALID already high at reset release is ignored.
  assign w_accept   = rx.Rx_VALID & ~r_rx_valid_q;
  assign w_line_err = w_accept & (rx.Rx_FERROR | rx.Rx_PERROR);
  assign w_match    = (rx.Rx_DATA == w_exp_sym);
  assign w_is_sym0  = (rx.Rx_DATA == SYM0);

  always_comb begin
    w_exp_sym = SYM0;
    case (r_exp_idx)
      2'd0:    w_exp_sym = SYM0;
      2'd1:    w_exp_sym = SYM1;
      2'd2:    w_exp_sym = SYM2;
      default: w_exp_sym = SYM3;
    endcase
  end

  assign w_pass_inc = w_accept & ~w_line_err & (r_state == LOCK) & w_match
                    & (r_exp_idx == 2'd3);
  assign w_err_inc  = w_line_err | (w_accept & (r_state == LOCK) & ~w_match);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= HUNT;
      r_exp_idx    <= 2'd0;
      r_rx_valid_q <= 1'b1;
      r_sym_ok     <= 1'b0;
      r_sym_err    <= 1'b0;
      r_seq_done   <= 1'b0;
      r_last_rx    <= 8'h00;
    end else begin
      r_rx_valid_q <= rx.Rx_VALID;
      r_sym_ok     <= 1'b0;
      r_sym_err    <= 1'b0;
      r_seq_done   <= 1'b0;
      if (w_accept) begin
        r_last_rx <= rx.Rx_DATA;
        // A corrupted byte says nothing about alignment, so drop lock without comparing.
        if (w_line_err) begin
          r_sym_err <= 1'b1;
          r_state   <= HUNT;
          r_exp_idx <= 2'd0;
        end else begin
          case (r_state)
            HUNT: begin
              if (w_is_sym0) begin
                r_state   <= LOCK;
                r_exp_idx <= 2'd1;
                r_sym_ok  <= 1'b1;
              end
            end
            LOCK: begin
              if (w_match) begin
                r_sym_ok   <= 1'b1;
                r_exp_idx  <= r_exp_idx + 2'd1;
                r_seq_done <= (r_exp_idx == 2'd3);
              end else begin
                r_sym_err <= 1'b1;
                if (w_is_sym0) begin
                  r_exp_idx <= 2'd1;
                end else begin
                  r_state   <= HUNT;
                  r_exp_idx <= 2'd0;
                end
              end
            end
            default: begin
              r_state   <= HUNT;
              r_exp_idx <= 2'd0;
            end
          endcase
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_pass_inc),
    .o_q   (pass_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_err_inc),
    .o_q   (err_cnt)
  );

  assign locked   = (r_state == LOCK);
  assign exp_idx  = r_exp_idx;
  assign sym_ok   = r_sym_ok;
  assign sym_err  = r_sym_err;
  assign seq_done = r_seq_done;
  assign last_rx  = r_last_rx;

endmodule

// File: doc/uart_data_checker.md
Name: uart_data_checker

Overview:
Receive-side counterpart of the UART test-pattern source. The source cycles the 4-symbol pattern 0xAA, 0x55, 0xCC, 0x89 into the transmitter. This block sits on the receiver output and consumes each received byte. It checks each byte against the expected position in that pattern, keeps saturating pass/error statistics, and flags completed sequences for the loopback bench and board LEDs.

Parameters:
SYM0, 8'hAA, expected symbol 0 (sync symbol)
SYM1, 8'h55, expected symbol 1
SYM2, 8'hCC, expected symbol 2
SYM3, 8'h89, expected symbol 3
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
Rx_DATA  input  8  received byte; valid while Rx_VALID=1
Rx_VALID  input  1  receiver data-valid level; may stay high for many clk cycles
Rx_FERROR  input  1  framing error for current byte; sampled with Rx_VALID
Rx_PERROR  input  1  parity error for current byte; sampled with Rx_VALID
locked  output  1  1 = aligned to pattern, comparing positionally
exp_idx  output  2  index of next expected symbol (0..3)
sym_ok  output  1  one-cycle pulse: byte matched expectation
sym_err  output  1  one-cycle pulse: mismatch or line error
seq_done  output  1  one-cycle pulse: SYM3 matched, full sequence received
last_rx  output  8  last accepted byte, line-error bytes included
pass_cnt  output  CNT_W  count of completed sequences, saturating
err_cnt  output  CNT_W  count of mismatch + line-error events, saturating

Behaviour:
- Reset (reset=0, asynchronous): state=HUNT, locked=0, exp_idx=0, all pulses=0, last_rx=0, pass_cnt=0, err_cnt=0, rx_valid_q=1.
  - rx_valid_q=1 blocks a false accept when Rx_VALID is already high as reset is released.
- Byte accept:
  - rx_valid_q registers Rx_VALID.
  - accept = Rx_VALID & ~rx_valid_q, i.e. the rising edge. Exactly one accept per Rx_VALID assertion, however long it is held.
  - Rx_DATA/Rx_FERROR/Rx_PERROR are sampled in the accept cycle.
  - Outputs update on the clk edge ending the accept cycle: latency 1 clk.
- Line error (accept & (Rx_FERROR|Rx_PERROR)):
  - sym_err=1, err_cnt+1, last_rx=Rx_DATA.
  - State -> HUNT, exp_idx=0, locked=0.
  - Data is not compared. Line error takes priority over the compare.
- FSM states: HUNT, LOCK.
  - HUNT, accept, Rx_DATA==SYM0: -> LOCK, exp_idx=1, sym_ok=1. Not an error.
  - HUNT, accept, other byte: stay HUNT, no pulse, no count. Discarded during sync.
  - LOCK, accept, Rx_DATA==SYM[exp_idx]: sym_ok=1, exp_idx+1 (wraps 3->0).
    - On idx 3: seq_done=1, pass_cnt+1; stay LOCK, next expected SYM0.
  - LOCK, accept, mismatch: sym_err=1, err_cnt+1.
    - If Rx_DATA==SYM0: stay LOCK with exp_idx=1 (immediate resync).
    - Otherwise: -> HUNT, exp_idx=0.
- locked = (state==LOCK), registered.
- Counters saturate at all-ones; no wrap.
- Pulses are single-cycle and deassert the next clk even if Rx_VALID stays high.
- Reset mid-byte clears all state. A held Rx_VALID after reset release is not accepted (rx_valid_q=1 at reset).

Decomposition:
- Shared package uart_pkg:
  - default symbol constants SYM0..SYM3, shared with the pattern source;
  - checker state enum {HUNT, LOCK};
  - CNT_W default.
- One sub-module is natural: sat_counter (CNT_W, inc, q, async active-low reset). Instantiated twice, for pass_cnt and err_cnt.
- Edge detect and FSM stay in the top.

Test Plan:
1. Reset, then bytes AA,55,CC,89 (Rx_VALID 1-clk pulses, no errors) -> 4 sym_ok pulses, seq_done on the 4th, pass_cnt=1, err_cnt=0, locked=1, exp_idx=0.
2. Bytes 12,34 then AA,55,CC,89,AA -> no pulses for 12/34; pass_cnt=1, err_cnt=0, final exp_idx=1, locked=1.
3. While locked with exp_idx=2, byte AA -> sym_err, err_cnt=1, locked stays 1, exp_idx=1. Then byte 77 with exp_idx=1 -> sym_err, err_cnt=2, locked=0, exp_idx=0.
4. Locked, byte 55 with Rx_PERROR=1 (correct data) -> sym_err, err_cnt+1, locked=0, last_rx=55. Repeat with Rx_FERROR=1 -> same.
5. Rx_VALID held high 20 clk with data AA -> exactly one sym_ok pulse. Assert reset mid-hold and release while Rx_VALID is still high -> no accept, all outputs zero.
6. Force err_cnt to near-saturation (CNT_W=4): 20 mismatches -> err_cnt stops at 15, sym_err still pulses each time.
